// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and widths for the boot-time program loader.
// Optional checksum feature is enabled by defining IMEM_LOADER_CKSUM_EN.
package imem_loader_pkg;

  // Loader life cycle: fill imem, settle, run the CPU, or stop on error.
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_e;

  // Width of the post-load settle counter (RST_HOLD is at most 255).
  localparam int HOLD_W  = 8;

  // Width of the running program checksum.
  localparam int CKSUM_W = 32;

endpackage

// File: rtl/imem_loader_cksum.sv
// imem_loader_cksum: running mod-2^32 sum of program words, compared against
// the checksum beat that closes the stream. Only instantiated when
// IMEM_LOADER_CKSUM_EN is defined.
module imem_loader_cksum
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_add,
  input  logic [CKSUM_W-1:0] i_data,
  input  logic [CKSUM_W-1:0] i_cmp,
  output logic               o_match
);

  logic [CKSUM_W-1:0] r_sum;

  // Accumulate every word written to imem; clear on reset or once consumed.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_match = (r_sum == i_cmp);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words into imem from address 0,
// holds the CPU in reset during the load plus RST_HOLD settle cycles, then
// releases it. Define IMEM_LOADER_CKSUM_EN to treat the in_last beat as a
// checksum of all prior words instead of an instruction.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err_overflow,
  output logic              err_cksum,
  output logic [ADDR_W:0]   word_count
);

  // word_count is one bit wider than the address so it can hold DEPTH itself.
  localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);

  state_e              r_state;
  state_e              w_state_next;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [31:0]         r_imem_wdata;
  logic [ADDR_W:0]     r_word_count;
  logic                r_err_overflow;

  logic                w_accept;
  logic                w_write;
  logic                w_overflow;
  logic                w_hold_load;

`ifdef IMEM_LOADER_CKSUM_EN
  logic                w_ck_match;
  logic                w_ck_bad;
  logic                r_err_cksum;
`endif

  assign in_ready = (r_state == LOAD) && !rst;
  assign w_accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the one-cycle actions that go with each transition.
  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    w_overflow   = 1'b0;
    w_hold_load  = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    w_ck_bad     = 1'b0;
`endif
    case (r_state)
      LOAD: begin
        if (w_accept) begin
`ifdef IMEM_LOADER_CKSUM_EN
          // The closing beat is a checksum: never written, never counted,
          // so it is legal even when imem is already full.
          if (in_last) begin
            if (w_ck_match) begin
              w_state_next = HOLD;
              w_hold_load  = 1'b1;
            end else begin
              w_state_next = ERR;
              w_ck_bad     = 1'b1;
            end
          end else
`endif
          if (r_word_count == DEPTH) begin
            // imem is full: drop the beat rather than wrap over address 0.
            w_state_next = ERR;
            w_overflow   = 1'b1;
          end else begin
            w_write = 1'b1;
            if (in_last) begin
              w_state_next = HOLD;
              w_hold_load  = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        // Counter is loaded with RST_HOLD, so HOLD lasts exactly RST_HOLD cycles.
        if (r_hold_cnt <= HOLD_W'(1)) begin
          w_state_next = RUN;
        end
      end
      RUN:     w_state_next = RUN;
      ERR:     w_state_next = ERR;
      default: w_state_next = LOAD;
    endcase
  end

  // Settle counter: loaded on the final beat, counts down through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (w_hold_load) begin
      r_hold_cnt <= HOLD_INIT;
    end else if ((r_state == HOLD) && (r_hold_cnt != '0)) begin
      r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
    end
  end

  // Registered imem write port, word counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= '0;
      r_word_count   <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      r_imem_we <= w_write;
      if (w_write) begin
        r_imem_addr  <= r_word_count[ADDR_W-1:0];
        r_imem_wdata <= in_data;
        r_word_count <= r_word_count + 1'b1;
      end
      if (w_overflow) begin
        r_err_overflow <= 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  imem_loader_cksum u_cksum (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accept && in_last),
    .i_add   (w_write),
    .i_data  (in_data),
    .i_cmp   (in_data),
    .o_match (w_ck_match)
  );

  // Sticky checksum error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cksum <= 1'b0;
    end else if (w_ck_bad) begin
      r_err_cksum <= 1'b1;
    end
  end

  assign err_cksum = r_err_cksum;
`else
  assign err_cksum = 1'b0;
`endif

  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign word_count   = r_word_count;
  assign err_overflow = r_err_overflow;
  assign cpu_rst      = (r_state != RUN);
  assign done         = (r_state == RUN);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus for imem_loader (ADDR_W=2, RST_HOLD=4)
// checked every cycle against a transaction-level model, plus literal checks.
// Follows IMEM_LOADER_CKSUM_EN if the build defines it.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int ADDR_W   = 2;
  localparam int RST_HOLD = 4;
  localparam int DEPTH    = 4;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err_overflow;
  logic              err_cksum;
  logic [ADDR_W:0]   word_count;

  imem_loader #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .err_overflow (err_overflow),
    .err_cksum    (err_cksum),
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Model: what the loader has been told, and when the CPU must be released.
  bit          m_loading    = 1'b1;
  bit          m_we         = 1'b0;
  bit          m_err_ovf    = 1'b0;
  bit          m_err_ck     = 1'b0;
  int          m_words      = 0;
  int          m_release_at = -1;
  int          m_addr       = 0;
  logic [31:0] m_wdata      = '0;
  logic [31:0] m_sum        = '0;

  typedef struct {
    int          c;
    int          a;
    logic [31:0] d;
  } wr_t;
  wr_t wlog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model update on every rising edge, from the inputs the bench applied.
  always @(posedge clk) begin
    cyc++;
    m_we = 1'b0;
    if (rst) begin
      m_loading = 1'b1; m_err_ovf = 1'b0; m_err_ck = 1'b0;
      m_words = 0; m_release_at = -1; m_sum = '0;
    end else if (in_valid && m_loading) begin
      if (CK && in_last) begin
        m_loading = 1'b0;
        if (in_data == m_sum) m_release_at = cyc + RST_HOLD;
        else                  m_err_ck = 1'b1;
      end else if (m_words == DEPTH) begin
        m_loading = 1'b0;
        m_err_ovf = 1'b1;
      end else begin
        m_we = 1'b1; m_addr = m_words; m_wdata = in_data;
        m_words++;
        m_sum = m_sum + in_data;
        if (in_last) begin
          m_loading = 1'b0;
          m_release_at = cyc + RST_HOLD;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, m_loading && !rst);
      chk("imem_we", imem_we, m_we);
      if (m_we) begin
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, m_wdata);
      end
      chk("cpu_rst", cpu_rst, !(m_release_at >= 0 && cyc >= m_release_at));
      chk("done", done, (m_release_at >= 0 && cyc >= m_release_at));
      chk("err_overflow", err_overflow, m_err_ovf);
      chk("err_cksum", err_cksum, m_err_ck);
      chk("word_count", word_count, m_words);
    end
  end

  // Write log used by the literal checks; one line per imem write.
  always @(negedge clk) begin
    if (imem_we) begin
      wlog.push_back('{cyc, int'(imem_addr), imem_wdata});
      $display("cycle %0d: imem write addr=%0d data=0x%08h", cyc, imem_addr, imem_wdata);
    end
  end

  task automatic beat(input logic v, input logic [31:0] d, input logic l);
    in_valid = v; in_data = d; in_last = l;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    beat(1'b0, 32'h0, 1'b0);
    beat(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
  endtask

  // Sends n words (optionally with an idle gap carrying a stray in_last),
  // closing with in_last on the final word, or with a checksum beat.
  task automatic send_prog(input logic [31:0] w [8], input int n, input bit gap);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) beat(1'b0, 32'hDEADBEEF, 1'b1);
      beat(1'b1, w[i], (!CK && i == n - 1));
      s = s + w[i];
    end
    if (CK) begin
      if (gap) beat(1'b0, 32'hDEADBEEF, 1'b1);
      beat(1'b1, s, 1'b1);
    end
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        c = cyc;
        break;
      end
      beat(1'b0, 32'h0, 1'b0);
    end
    chk("done_within_bound", (c >= 0), 1'b1);
  endtask

  task automatic check_writes(input string name, input int base, input logic [31:0] w [8],
                              input int n, input int spacing);
    chk({name, "_count"}, wlog.size() - base, n);
    if (wlog.size() - base == n) begin
      for (int i = 0; i < n; i++) begin
        chk({name, "_addr"}, wlog[base + i].a, i);
        chk({name, "_data"}, wlog[base + i].d, w[i]);
        if (i > 0) chk({name, "_spacing"}, wlog[base + i].c - wlog[base + i - 1].c, spacing);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  logic [31:0] prog [8];
  int          base;
  int          rel;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset values, literal.
    chk("rst_imem_we", imem_we, 1'b0);
    chk("rst_imem_addr", imem_addr, 2'd0);
    chk("rst_imem_wdata", imem_wdata, 32'h0);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err_overflow", err_overflow, 1'b0);
    chk("rst_err_cksum", err_cksum, 1'b0);
    chk("rst_word_count", word_count, 3'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk_en = 1'b1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1'b1);

    // Three back-to-back words.
    base = wlog.size();
    prog = '{32'h20010005, 32'h20020007, 32'h00221820, 0, 0, 0, 0, 0};
    send_prog(prog, 3, 1'b0);
    wait_done(rel);
    check_writes("t1", base, prog, 3, 1);
    chk("t1_word_count", word_count, 3'd3);
    if (wlog.size() - base == 3)
      chk("t1_release_delay", rel - wlog[base + 2].c, CK ? 5 : 4);

    // RUN ignores further input.
    base = wlog.size();
    for (int i = 0; i < 10; i++) beat(1'b1, 32'hFFFF0000 + i, (i == 9));
    beat(1'b0, 32'h0, 1'b0);
    chk("run_no_writes", wlog.size() - base, 0);
    chk("run_done", done, 1'b1);
    chk("run_in_ready", in_ready, 1'b0);

    // Gapped stream of four words.
    do_reset();
    base = wlog.size();
    prog = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 0, 0};
    send_prog(prog, 4, 1'b1);
    wait_done(rel);
    check_writes("gap", base, prog, 4, 2);
    chk("gap_word_count", word_count, 3'd4);

    // Reset after two of four words, then reload from address 0.
    do_reset();
    beat(1'b1, 32'hAAAA0001, 1'b0);
    beat(1'b1, 32'hAAAA0002, 1'b0);
    rst = 1'b1;
    beat(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_word_count", word_count, 3'd0);
    chk("mid_rst_done", done, 1'b0);
    base = wlog.size();
    prog = '{32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003, 32'hBBBB0004, 0, 0, 0, 0};
    send_prog(prog, 4, 1'b0);
    wait_done(rel);
    check_writes("reload", base, prog, 4, 1);

    // Overflow: five words into a four-word imem, no in_last.
    do_reset();
    base = wlog.size();
    prog = '{32'h000000A0, 32'h000000A1, 32'h000000A2, 32'h000000A3, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) beat(1'b1, 32'h000000A0 + i, 1'b0);
    for (int i = 0; i < 3; i++) beat(1'b0, 32'h0, 1'b0);
    check_writes("ovf", base, prog, 4, 1);
    chk("ovf_flag", err_overflow, 1'b1);
    chk("ovf_cpu_rst", cpu_rst, 1'b1);
    chk("ovf_word_count", word_count, 3'd4);
    chk("ovf_in_ready", in_ready, 1'b0);
    do_reset();
    chk("ovf_cleared", err_overflow, 1'b0);
    chk("ovf_in_ready_back", in_ready, 1'b1);

`ifdef IMEM_LOADER_CKSUM_EN
    // Checksum 6 over words 1,2,3 releases the CPU.
    base = wlog.size();
    prog = '{32'd1, 32'd2, 32'd3, 0, 0, 0, 0, 0};
    send_prog(prog, 3, 1'b0);
    wait_done(rel);
    check_writes("ck_ok", base, prog, 3, 1);
    chk("ck_ok_word_count", word_count, 3'd3);

    // Checksum 7 is rejected and the CPU is never released.
    do_reset();
    base = wlog.size();
    beat(1'b1, 32'd1, 1'b0);
    beat(1'b1, 32'd2, 1'b0);
    beat(1'b1, 32'd3, 1'b0);
    beat(1'b1, 32'd7, 1'b1);
    for (int i = 0; i < 10; i++) beat(1'b0, 32'h0, 1'b0);
    check_writes("ck_bad", base, prog, 3, 1);
    chk("ck_bad_flag", err_cksum, 1'b1);
    chk("ck_bad_cpu_rst", cpu_rst, 1'b1);
    chk("ck_bad_done", done, 1'b0);
`endif

    beat(1'b0, 32'h0, 1'b0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
